// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard and forwarding controller for the five-stage pipeline. It handles
//   M/W forwarding into the ALU and into the decode branch comparator,
//   load-use and branch interlocks, a multi-cycle divider stall FSM,
//   exception flush, and a saturating count of cycles with stallF set.
//
// Ports
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   rsD, rtD, branchD, jrD      decode sources and branch / jr flags
//   rsE, rtE, writeregE         execute sources and destination
//   regwriteE, memtoregE        execute write enable and load flag
//   divstartE                   execute holds div/mult, held while E is stalled
//   writeregM, regwriteM,
//   memtoregM, exceptM          memory-stage destination, control, exception
//   writeregW, regwriteW        write-back destination and enable
//   forwardaD/bD, forwardaE/bE  operand select: 00 regfile, 01 W, 10 M
//   stallF/D/E                  hold PC, IF/ID and ID/EX
//   flushD/E/M/W                clear the respective pipeline register
//   divbusy                     divider FSM is not IDLE
//   stall_cycles                saturating count of cycles with stallF=1
//
// Divider FSM
//   state | meaning
//   IDLE  | no divide in flight; a divstartE stalls this cycle and launches one
//   BUSY  | divide running; down-counter reaches 0 on the last stall cycle
//   DONE  | result ready, E advances; divstartE ignored so the op is not re-run
module hazard_unit_mc #(
  parameter int AW      = 5,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rsD,
  input  logic [AW-1:0]    rtD,
  input  logic             branchD,
  input  logic             jrD,
  input  logic [AW-1:0]    rsE,
  input  logic [AW-1:0]    rtE,
  input  logic [AW-1:0]    writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic             divstartE,
  input  logic [AW-1:0]    writeregM,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic             exceptM,
  input  logic [AW-1:0]    writeregW,
  input  logic             regwriteW,
  output logic [1:0]       forwardaD,
  output logic [1:0]       forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             divbusy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          divstall;
  logic          lwstall;
  logic          brstall;
  logic          dep_rsE, dep_rtE, dep_rsM, dep_rtM;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic [AW-1:0] wreg_m,
    input logic          wen_m,
    input logic [AW-1:0] wreg_w,
    input logic          wen_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (wen_m && (src == wreg_m))      sel = 2'b10;
      else if (wen_w && (src == wreg_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
    forwardaD = fwd_sel(rsD, writeregM, regwriteM, writeregW, regwriteW);
    forwardbD = fwd_sel(rtD, writeregM, regwriteM, writeregW, regwriteW);
  end

  always_comb begin
    lwstall = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));

    // Branch operands are compared in decode: a result still in E, or a load
    // still in M, is not yet forwardable.
    dep_rsE = regwriteE && (writeregE != '0) && (writeregE == rsD);
    dep_rtE = regwriteE && (writeregE != '0) && (writeregE == rtD);
    dep_rsM = memtoregM && (writeregM != '0) && (writeregM == rsD);
    dep_rtM = memtoregM && (writeregM != '0) && (writeregM == rtD);

    brstall = (branchD && (dep_rsE || dep_rtE || dep_rsM || dep_rtM)) ||
              (jrD && (dep_rsE || dep_rsM));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    divstall  = 1'b0;
    case (state)
      IDLE: begin
        divstall = divstartE;
        if (divstartE) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        divstall = 1'b1;
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // An exception kills the divide in flight and blocks a new launch.
    if (exceptM) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      stallF = lwstall || brstall || divstall;
      stallD = stallF;
      stallE = divstall;
      // While E is held by the divider the bubble would overwrite the live op.
      flushE = (lwstall || brstall) && !divstall;
    end
  end

  assign divbusy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stallF && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
